// File: rtl/bram_port_arbiter_if.sv
// Requester-side handshake bundle for one BRAM client (host or sequencer).
// The requester uses the master modport and the arbiter uses the slave modport.
interface bram_port_arbiter_if #(
   parameter int AW = 12,
   parameter int DW = 8
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between the EPP host and the acquisition sequencer.
// Define BRAM_ARB_ROUND_ROBIN_EN for alternating priority; otherwise the sequencer wins unless the host has waited MAX_WAIT cycles.
module bram_port_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   bram_port_arbiter_if.slave        h_if,
   bram_port_arbiter_if.slave        s_if,
   output logic                      bram_en,
   output logic                      bram_we,
   output logic [AW-1:0]             bram_addr,
   output logic [DW-1:0]             bram_din,
   input  logic [DW-1:0]             bram_dout,
   output logic                      stm_busy
);

   logic          h_gnt, s_gnt, prio_h;

   logic          bram_en_d,   bram_en_q;
   logic          bram_we_d,   bram_we_q;
   logic [AW-1:0] bram_addr_d, bram_addr_q;
   logic [DW-1:0] bram_din_d,  bram_din_q;
   logic          own1_d,      own1_q;
   logic          acc2_d,      acc2_q;
   logic          we2_d,       we2_q;
   logic          own2_d,      own2_q;
   logic          h_rvalid_d,  h_rvalid_q;
   logic          s_rvalid_d,  s_rvalid_q;
   logic [DW-1:0] h_rdata_d,   h_rdata_q;
   logic [DW-1:0] s_rdata_d,   s_rdata_q;
   logic          stm_busy_d,  stm_busy_q;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
   // 1 = sequencer won the most recent grant
   logic          last_winner_d, last_winner_q;

   always_comb begin
      prio_h        = last_winner_q;
      last_winner_d = last_winner_q;
      if (s_gnt)
         last_winner_d = 1'b1;
      else if (h_gnt)
         last_winner_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_winner_q <= 1'b0;
      else
         last_winner_q <= last_winner_d;
   end
`else
   logic [7:0]    wait_cnt_d, wait_cnt_q;

   always_comb begin
      prio_h     = (wait_cnt_q >= 8'(MAX_WAIT));
      wait_cnt_d = 8'd0;
      if (h_if.req && !h_gnt)
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt_q <= 8'd0;
      else
         wait_cnt_q <= wait_cnt_d;
   end
`endif

   // Grants are suppressed during reset so nothing is accepted while flushing.
   assign h_gnt = h_if.req && !rst && (!s_if.req || prio_h);
   assign s_gnt = s_if.req && !rst && !h_gnt;

   always_comb begin
      bram_en_d   = h_gnt || s_gnt;
      bram_we_d   = h_gnt ? h_if.we : (s_gnt && s_if.we);
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      if (h_gnt) begin
         bram_addr_d = h_if.addr;
         bram_din_d  = h_if.wdata;
      end else if (s_gnt) begin
         bram_addr_d = s_if.addr;
         bram_din_d  = s_if.wdata;
      end
      own1_d = s_gnt;

      acc2_d = bram_en_q;
      we2_d  = bram_we_q;
      own2_d = own1_q;

      // bram_dout is valid in stage 2; capture it for the owning requester
      h_rvalid_d = acc2_q && !we2_q && !own2_q;
      s_rvalid_d = acc2_q && !we2_q &&  own2_q;
      h_rdata_d  = h_rvalid_d ? bram_dout : h_rdata_q;
      s_rdata_d  = s_rvalid_d ? bram_dout : s_rdata_q;

      stm_busy_d = s_if.req || (bram_en_q && own1_q) || (acc2_q && own2_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bram_en_q   <= 1'b0;
         bram_we_q   <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         own1_q      <= 1'b0;
         acc2_q      <= 1'b0;
         we2_q       <= 1'b0;
         own2_q      <= 1'b0;
         h_rvalid_q  <= 1'b0;
         s_rvalid_q  <= 1'b0;
         h_rdata_q   <= '0;
         s_rdata_q   <= '0;
         stm_busy_q  <= 1'b0;
      end else begin
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         own1_q      <= own1_d;
         acc2_q      <= acc2_d;
         we2_q       <= we2_d;
         own2_q      <= own2_d;
         h_rvalid_q  <= h_rvalid_d;
         s_rvalid_q  <= s_rvalid_d;
         h_rdata_q   <= h_rdata_d;
         s_rdata_q   <= s_rdata_d;
         stm_busy_q  <= stm_busy_d;
      end
   end

   assign h_if.gnt    = h_gnt;
   assign s_if.gnt    = s_gnt;
   assign h_if.rvalid = h_rvalid_q;
   assign s_if.rvalid = s_rvalid_q;
   assign h_if.rdata  = h_rdata_q;
   assign s_if.rdata  = s_rdata_q;
   assign bram_en     = bram_en_q;
   assign bram_we     = bram_we_q;
   assign bram_addr   = bram_addr_q;
   assign bram_din    = bram_din_q;
   assign stm_busy    = stm_busy_q;

endmodule
